// File: rtl/clic_irq_arbiter.sv
// CLIC interrupt selection: qualify pending/enabled sources, pick the highest-ctl winner
// through a two-stage registered pipeline, and hand it to the core over valid/ready with kill preemption.
module clic_irq_arbiter #(
    parameter  int NumSrc     = 256,
    parameter  int IntCtlBits = 8,
    parameter  int NlBits     = 4,
    localparam int SrcW       = $clog2(NumSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumSrc-1:0]            ip_i,
    input  logic [NumSrc-1:0]            ie_i,
    input  logic [NumSrc*IntCtlBits-1:0] ctl_i,
    input  logic [NumSrc-1:0]            shv_i,
    input  logic [NumSrc-1:0]            trig_edge_i,
    input  logic [7:0]                   mintthresh_i,
    output logic                         irq_valid_o,
    input  logic                         irq_ready_i,
    output logic [SrcW-1:0]              irq_id_o,
    output logic [7:0]                   irq_level_o,
    output logic                         irq_shv_o,
    output logic                         irq_kill_req_o,
    input  logic                         irq_kill_ack_i,
    output logic [NumSrc-1:0]            ip_clear_o
);

    localparam int NumLeaf = 1 << SrcW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_KILL  = 2'd2;
    localparam logic [1:0] ST_BLANK = 2'd3;

    // Level = NlBits MSBs of ctl left-aligned in 8 bits, remaining bits forced to 1.
    function automatic logic [7:0] level_of(input logic [IntCtlBits-1:0] ctl);
        logic [7:0] lvl;
        lvl = 8'hFF;
        for (int i = 0; i < NlBits; i++) begin
            lvl[7-i] = ctl[IntCtlBits-1-i];
        end
        return lvl;
    endfunction

    logic [NumSrc-1:0]            s1_q_q, s1_q_d;
    logic [NumSrc*IntCtlBits-1:0] s1_ctl_q, s1_ctl_d;
    logic [NumSrc-1:0]            s1_shv_q, s1_shv_d;
    logic [NumSrc-1:0]            s1_trig_q, s1_trig_d;

    logic                  win_valid_q, win_valid_d;
    logic [SrcW-1:0]       win_id_q, win_id_d;
    logic [IntCtlBits-1:0] win_ctl_q, win_ctl_d;
    logic                  win_shv_q, win_shv_d;
    logic                  win_trig_q, win_trig_d;

    logic [1:0]        state_q, state_d;
    logic              irq_valid_q, irq_valid_d;
    logic [SrcW-1:0]   irq_id_q, irq_id_d;
    logic [7:0]        irq_level_q, irq_level_d;
    logic              irq_shv_q, irq_shv_d;
    logic              irq_trig_q, irq_trig_d;
    logic              irq_kill_q, irq_kill_d;
    logic [NumSrc-1:0] ip_clear_q, ip_clear_d;

    // The source being cleared is masked out of stage 1 for the accept cycle and the
    // pulse cycle, so ip values sampled before the clear lands cannot re-request it.
    always_comb begin
        s1_q_d    = ip_i & ie_i & ~(ip_clear_d | ip_clear_q);
        s1_ctl_d  = ctl_i;
        s1_shv_d  = shv_i;
        s1_trig_d = trig_edge_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q_q    <= '0;
            s1_ctl_q  <= '0;
            s1_shv_q  <= '0;
            s1_trig_q <= '0;
        end else begin
            s1_q_q    <= s1_q_d;
            s1_ctl_q  <= s1_ctl_d;
            s1_shv_q  <= s1_shv_d;
            s1_trig_q <= s1_trig_d;
        end
    end

    // Binary max-tree; left child always holds the lower ids, so ">=" hands ties to the higher id.
    for (genvar lv = 0; lv <= SrcW; lv++) begin : g_lvl
        localparam int N = NumLeaf >> lv;
        logic                  v [N];
        logic [IntCtlBits-1:0] c [N];
        logic [SrcW-1:0]       id[N];
        logic                  s [N];
        logic                  t [N];
        for (genvar gi = 0; gi < N; gi++) begin : g_node
            if (lv == 0) begin : g_leaf
                if (gi < NumSrc) begin : g_src
                    assign v[gi]  = s1_q_q[gi];
                    assign c[gi]  = s1_ctl_q[gi*IntCtlBits +: IntCtlBits];
                    assign id[gi] = SrcW'(gi);
                    assign s[gi]  = s1_shv_q[gi];
                    assign t[gi]  = s1_trig_q[gi];
                end else begin : g_pad
                    assign v[gi]  = 1'b0;
                    assign c[gi]  = '0;
                    assign id[gi] = '0;
                    assign s[gi]  = 1'b0;
                    assign t[gi]  = 1'b0;
                end
            end else begin : g_cmp
                logic pick_hi;
                assign pick_hi = g_lvl[lv-1].v[2*gi+1] &
                                 (~g_lvl[lv-1].v[2*gi] |
                                  (g_lvl[lv-1].c[2*gi+1] >= g_lvl[lv-1].c[2*gi]));
                assign v[gi]  = g_lvl[lv-1].v[2*gi] | g_lvl[lv-1].v[2*gi+1];
                assign c[gi]  = pick_hi ? g_lvl[lv-1].c[2*gi+1]  : g_lvl[lv-1].c[2*gi];
                assign id[gi] = pick_hi ? g_lvl[lv-1].id[2*gi+1] : g_lvl[lv-1].id[2*gi];
                assign s[gi]  = pick_hi ? g_lvl[lv-1].s[2*gi+1]  : g_lvl[lv-1].s[2*gi];
                assign t[gi]  = pick_hi ? g_lvl[lv-1].t[2*gi+1]  : g_lvl[lv-1].t[2*gi];
            end
        end
    end

    always_comb begin
        win_valid_d = g_lvl[SrcW].v[0] && (level_of(g_lvl[SrcW].c[0]) > mintthresh_i);
        win_id_d    = g_lvl[SrcW].id[0];
        win_ctl_d   = g_lvl[SrcW].c[0];
        win_shv_d   = g_lvl[SrcW].s[0];
        win_trig_d  = g_lvl[SrcW].t[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_valid_q <= 1'b0;
            win_id_q    <= '0;
            win_ctl_q   <= '0;
            win_shv_q   <= 1'b0;
            win_trig_q  <= 1'b0;
        end else begin
            win_valid_q <= win_valid_d;
            win_id_q    <= win_id_d;
            win_ctl_q   <= win_ctl_d;
            win_shv_q   <= win_shv_d;
            win_trig_q  <= win_trig_d;
        end
    end

    always_comb begin
        logic accept;
        accept      = 1'b0;
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        irq_level_d = irq_level_q;
        irq_shv_d   = irq_shv_q;
        irq_trig_d  = irq_trig_q;
        irq_kill_d  = irq_kill_q;
        ip_clear_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_q) begin
                    state_d     = ST_REQ;
                    irq_valid_d = 1'b1;
                    irq_id_d    = win_id_q;
                    irq_level_d = level_of(win_ctl_q);
                    irq_shv_d   = win_shv_q;
                    irq_trig_d  = win_trig_q;
                end
            end
            ST_REQ: begin
                if (irq_ready_i) begin
                    accept = 1'b1;
                end else if (!win_valid_q || (win_id_q != irq_id_q)) begin
                    state_d    = ST_KILL;
                    irq_kill_d = 1'b1;
                end
            end
            ST_KILL: begin
                if (irq_ready_i) begin
                    accept = 1'b1;
                end else if (irq_kill_ack_i) begin
                    state_d     = ST_BLANK;
                    irq_valid_d = 1'b0;
                    irq_kill_d  = 1'b0;
                    irq_id_d    = '0;
                    irq_level_d = '0;
                    irq_shv_d   = 1'b0;
                    irq_trig_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            state_d     = ST_BLANK;
            irq_valid_d = 1'b0;
            irq_kill_d  = 1'b0;
            irq_id_d    = '0;
            irq_level_d = '0;
            irq_shv_d   = 1'b0;
            irq_trig_d  = 1'b0;
            if (irq_trig_q) begin
                ip_clear_d = {{(NumSrc-1){1'b0}}, 1'b1} << irq_id_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            irq_level_q <= '0;
            irq_shv_q   <= 1'b0;
            irq_trig_q  <= 1'b0;
            irq_kill_q  <= 1'b0;
            ip_clear_q  <= '0;
        end else begin
            state_q     <= state_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            irq_level_q <= irq_level_d;
            irq_shv_q   <= irq_shv_d;
            irq_trig_q  <= irq_trig_d;
            irq_kill_q  <= irq_kill_d;
            ip_clear_q  <= ip_clear_d;
        end
    end

    assign irq_valid_o    = irq_valid_q;
    assign irq_id_o       = irq_id_q;
    assign irq_level_o    = irq_level_q;
    assign irq_shv_o      = irq_shv_q;
    assign irq_kill_req_o = irq_kill_q;
    assign ip_clear_o     = ip_clear_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed bench for clic_irq_arbiter: latency, tie-break, threshold, kill preemption,
// ready/kill collisions, edge clear masking and asynchronous reset.
module tb_clic_irq_arbiter;

    localparam int NumSrc     = 256;
    localparam int IntCtlBits = 8;
    localparam int SrcW       = 8;

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b0;
    logic [NumSrc-1:0]            ip_i = '0;
    logic [NumSrc-1:0]            ie_i = '0;
    logic [NumSrc*IntCtlBits-1:0] ctl_i = '0;
    logic [NumSrc-1:0]            shv_i = '0;
    logic [NumSrc-1:0]            trig_edge_i = '0;
    logic [7:0]                   mintthresh_i = '0;
    logic                         irq_valid_o;
    logic                         irq_ready_i = 1'b0;
    logic [SrcW-1:0]              irq_id_o;
    logic [7:0]                   irq_level_o;
    logic                         irq_shv_o;
    logic                         irq_kill_req_o;
    logic                         irq_kill_ack_i = 1'b0;
    logic [NumSrc-1:0]            ip_clear_o;

    int n_cmp = 0;
    int n_err = 0;

    clic_irq_arbiter #(.NumSrc(NumSrc), .IntCtlBits(IntCtlBits), .NlBits(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ip_i           (ip_i),
        .ie_i           (ie_i),
        .ctl_i          (ctl_i),
        .shv_i          (shv_i),
        .trig_edge_i    (trig_edge_i),
        .mintthresh_i   (mintthresh_i),
        .irq_valid_o    (irq_valid_o),
        .irq_ready_i    (irq_ready_i),
        .irq_id_o       (irq_id_o),
        .irq_level_o    (irq_level_o),
        .irq_shv_o      (irq_shv_o),
        .irq_kill_req_o (irq_kill_req_o),
        .irq_kill_ack_i (irq_kill_ack_i),
        .ip_clear_o     (ip_clear_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] onehot(input int id);
        logic [255:0] r;
        r = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    task automatic set_src(input int id, input logic [7:0] ctl, input logic is_edge, input logic shv);
        ctl_i[id*IntCtlBits +: IntCtlBits] = ctl;
        trig_edge_i[id] = is_edge;
        shv_i[id]       = shv;
        ie_i[id]        = 1'b1;
    endtask

    task automatic do_reset();
        rst_ni         = 1'b0;
        ip_i           = '0;
        ie_i           = '0;
        ctl_i          = '0;
        shv_i          = '0;
        trig_edge_i    = '0;
        mintthresh_i   = '0;
        irq_ready_i    = 1'b0;
        irq_kill_ack_i = 1'b0;
        tick(2);
        rst_ni = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_valid", irq_valid_o, 0);
        chk("rst_kill", irq_kill_req_o, 0);
        chk("rst_clear", ip_clear_o, 0);

        // single edge source id 5, ctl 0x80
        $display("tx: single edge source 5 ctl 80");
        set_src(5, 8'h80, 1'b1, 1'b1);
        ip_i[5] = 1'b1;
        tick(); chk("t1_lat_e0", irq_valid_o, 0);
        tick(); chk("t1_lat_e1", irq_valid_o, 0);
        tick();
        chk("t1_valid", irq_valid_o, 1);
        chk("t1_id", irq_id_o, 5);
        chk("t1_level", irq_level_o, 8'h8F);
        chk("t1_shv", irq_shv_o, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_hold_valid", irq_valid_o, 1);
            chk("t1_hold_id", irq_id_o, 5);
            chk("t1_hold_kill", irq_kill_req_o, 0);
        end
        irq_ready_i = 1'b1;
        tick();
        chk("t1_acc_valid", irq_valid_o, 0);
        chk("t1_acc_clear", ip_clear_o, onehot(5));
        irq_ready_i = 1'b0;
        ip_i[5] = 1'b0;
        tick();
        chk("t1_clear_1cyc", ip_clear_o, 0);
        chk("t1_blank_valid", irq_valid_o, 0);
        tick(3);
        chk("t1_no_rereq", irq_valid_o, 0);

        // same source level-triggered: no clear, re-requests while still pending
        $display("tx: single level source 5 ctl 80");
        do_reset();
        set_src(5, 8'h80, 1'b0, 1'b0);
        ip_i[5] = 1'b1;
        tick(3);
        chk("t1b_valid", irq_valid_o, 1);
        irq_ready_i = 1'b1;
        tick();
        chk("t1b_acc_valid", irq_valid_o, 0);
        chk("t1b_no_clear", ip_clear_o, 0);
        irq_ready_i = 1'b0;
        tick();
        chk("t1b_blank", irq_valid_o, 0);
        tick();
        chk("t1b_rereq_valid", irq_valid_o, 1);
        chk("t1b_rereq_id", irq_id_o, 5);

        // tie-break on equal ctl, then id 3 raised above on a fresh request
        $display("tx: tie-break ids 3 and 200");
        do_reset();
        set_src(3, 8'h40, 1'b0, 1'b0);
        set_src(200, 8'h40, 1'b0, 1'b0);
        ip_i[3] = 1'b1;
        ip_i[200] = 1'b1;
        tick(3);
        chk("t2_valid", irq_valid_o, 1);
        chk("t2_tie_id", irq_id_o, 200);
        chk("t2_level", irq_level_o, 8'h4F);
        ctl_i[3*IntCtlBits +: IntCtlBits] = 8'h41;
        irq_ready_i = 1'b1;
        tick();
        chk("t2_acc_valid", irq_valid_o, 0);
        chk("t2_acc_kill", irq_kill_req_o, 0);
        irq_ready_i = 1'b0;
        tick();
        chk("t2_blank", irq_valid_o, 0);
        tick();
        chk("t2_new_valid", irq_valid_o, 1);
        chk("t2_new_id", irq_id_o, 3);

        // threshold
        $display("tx: threshold source 10 ctl 30");
        do_reset();
        set_src(10, 8'h30, 1'b0, 1'b0);
        mintthresh_i = 8'h3F;
        ip_i[10] = 1'b1;
        tick(5);
        chk("t3_below_thresh", irq_valid_o, 0);
        mintthresh_i = 8'h20;
        tick();
        chk("t3_lat1", irq_valid_o, 0);
        tick();
        chk("t3_valid", irq_valid_o, 1);
        chk("t3_id", irq_id_o, 10);
        chk("t3_level", irq_level_o, 8'h3F);

        // preemption by a higher source, held kill, then ack
        $display("tx: preempt id 7 by id 9");
        do_reset();
        set_src(7, 8'h40, 1'b0, 1'b0);
        ip_i[7] = 1'b1;
        tick(3);
        chk("t4_valid", irq_valid_o, 1);
        chk("t4_id", irq_id_o, 7);
        set_src(9, 8'hC0, 1'b0, 1'b1);
        ip_i[9] = 1'b1;
        tick(); chk("t4_kill_e0", irq_kill_req_o, 0);
        tick(); chk("t4_kill_e1", irq_kill_req_o, 0);
        tick();
        chk("t4_kill", irq_kill_req_o, 1);
        chk("t4_kill_valid", irq_valid_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold_kill", irq_kill_req_o, 1);
            chk("t4_hold_valid", irq_valid_o, 1);
            chk("t4_hold_id", irq_id_o, 7);
            chk("t4_hold_level", irq_level_o, 8'h4F);
        end
        irq_kill_ack_i = 1'b1;
        tick();
        chk("t4_ack_valid", irq_valid_o, 0);
        chk("t4_ack_kill", irq_kill_req_o, 0);
        irq_kill_ack_i = 1'b0;
        tick();
        chk("t4_blank", irq_valid_o, 0);
        tick();
        chk("t4_new_valid", irq_valid_o, 1);
        chk("t4_new_id", irq_id_o, 9);
        chk("t4_new_level", irq_level_o, 8'hCF);
        chk("t4_new_shv", irq_shv_o, 1);

        // ready in the same cycle the winner changes: accept, no kill
        $display("tx: ready collides with winner change in REQ");
        set_src(11, 8'hF0, 1'b0, 1'b0);
        ip_i[11] = 1'b1;
        tick(); chk("t5a_kill_e0", irq_kill_req_o, 0);
        tick();
        chk("t5a_kill_e1", irq_kill_req_o, 0);
        chk("t5a_id_e1", irq_id_o, 9);
        irq_ready_i = 1'b1;
        tick();
        chk("t5a_acc_valid", irq_valid_o, 0);
        chk("t5a_acc_kill", irq_kill_req_o, 0);
        irq_ready_i = 1'b0;

        // in KILL, ready and ack together: accept path with clear, no stale re-request
        $display("tx: ready+ack together in KILL on edge source 20");
        do_reset();
        set_src(20, 8'hC0, 1'b1, 1'b0);
        set_src(21, 8'h40, 1'b0, 1'b0);
        ip_i[20] = 1'b1;
        ip_i[21] = 1'b1;
        tick(3);
        chk("t5b_id", irq_id_o, 20);
        chk("t5b_level", irq_level_o, 8'hCF);
        set_src(22, 8'hF0, 1'b0, 1'b0);
        ip_i[22] = 1'b1;
        tick(3);
        chk("t5b_kill", irq_kill_req_o, 1);
        chk("t5b_kill_id", irq_id_o, 20);
        ip_i[22] = 1'b0;
        irq_ready_i = 1'b1;
        irq_kill_ack_i = 1'b1;
        tick();
        chk("t5b_acc_valid", irq_valid_o, 0);
        chk("t5b_acc_kill", irq_kill_req_o, 0);
        chk("t5b_acc_clear", ip_clear_o, onehot(20));
        irq_ready_i = 1'b0;
        irq_kill_ack_i = 1'b0;
        ip_i[20] = 1'b0;
        tick();
        chk("t5b_clear_1cyc", ip_clear_o, 0);
        chk("t5b_blank", irq_valid_o, 0);
        tick();
        chk("t5b_next_valid", irq_valid_o, 1);
        chk("t5b_next_id", irq_id_o, 21);
        chk("t5b_next_level", irq_level_o, 8'h4F);

        // asynchronous reset in the middle of KILL
        $display("tx: reset during KILL");
        do_reset();
        set_src(7, 8'h40, 1'b0, 1'b0);
        set_src(9, 8'hC0, 1'b0, 1'b0);
        ip_i[7] = 1'b1;
        tick(3);
        ip_i[9] = 1'b1;
        tick(3);
        chk("t6_kill_before", irq_kill_req_o, 1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("t6_async_valid", irq_valid_o, 0);
        chk("t6_async_kill", irq_kill_req_o, 0);
        chk("t6_async_id", irq_id_o, 0);
        chk("t6_async_level", irq_level_o, 0);
        tick();
        rst_ni = 1'b1;
        tick(); chk("t6_post_e1", irq_valid_o, 0);
        tick(); chk("t6_post_e2", irq_valid_o, 0);
        tick();
        chk("t6_post_valid", irq_valid_o, 1);
        chk("t6_post_id", irq_id_o, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
